// File: rtl/ap_fifo_job_dispatcher_if.sv
// Host stream and PE-array ap_fifo signals seen by the job dispatcher.
// master = dispatcher side, slave = shell/PE side.
interface ap_fifo_job_dispatcher_if #(
    parameter int NUM_PE = 4
);
    logic [31:0]          s_dout;
    logic                 s_empty_n;
    logic                 s_read;

    logic [32*NUM_PE-1:0] pe_in_din;
    logic [NUM_PE-1:0]    pe_in_full_n;
    logic [NUM_PE-1:0]    pe_in_write;

    logic [32*NUM_PE-1:0] pe_out_dout;
    logic [NUM_PE-1:0]    pe_out_empty_n;
    logic [NUM_PE-1:0]    pe_out_read;

    logic [31:0]          m_din;
    logic                 m_full;
    logic                 m_write;

    modport master (
        input  s_dout, s_empty_n, pe_in_full_n, pe_out_dout, pe_out_empty_n, m_full,
        output s_read, pe_in_din, pe_in_write, pe_out_read, m_din, m_write
    );

    modport slave (
        output s_dout, s_empty_n, pe_in_full_n, pe_out_dout, pe_out_empty_n, m_full,
        input  s_read, pe_in_din, pe_in_write, pe_out_read, m_din, m_write
    );
endinterface

// File: rtl/ap_fifo_job_dispatcher.sv
// Job dispatcher: routes host job payloads to NUM_PE ap_fifo PEs and returns an
// echo header plus result words to the host strictly in submission order.
//
// state    | meaning
// IN_HDR   | waiting for / reading a job header
// IN_PAY   | forwarding (or discarding, for a bad PE id) in_len payload words
// OUT_IDLE | popping the next job from the queue head
// OUT_HDR  | writing the echo header to the host
// OUT_DATA | copying out_len result words from the job's PE to the host
module ap_fifo_job_dispatcher #(
    parameter int NUM_PE     = 4,
    parameter int JOBQ_DEPTH = 8
) (
    input  logic                        ip_clk,
    input  logic                        srst,
    ap_fifo_job_dispatcher_if.master    bus,
    output logic [$clog2(JOBQ_DEPTH):0] jobq_level,
    output logic                        in_busy,
    output logic                        out_busy,
    output logic [7:0]                  bad_id_count
);
    localparam int QW = $clog2(JOBQ_DEPTH);

    typedef struct packed {
        logic [3:0]  pe_id;
        logic [11:0] out_len;
        logic [11:0] in_len;
        logic        bad;
    } job_t;

    typedef enum logic [0:0] {IN_HDR, IN_PAY} in_state_t;
    typedef enum logic [1:0] {OUT_IDLE, OUT_HDR, OUT_DATA} out_state_t;

    in_state_t  in_state, in_next;
    out_state_t out_state, out_next;

    logic [3:0]  in_pe;
    logic        in_bad;
    logic [11:0] in_cnt;

    job_t        cur_job;
    logic [11:0] out_cnt;

    job_t          jobq_mem [JOBQ_DEPTH];
    logic [QW-1:0] wr_ptr;
    logic [QW-1:0] rd_ptr;
    logic          q_full;
    logic          q_empty;
    logic          push;
    logic          pop;
    job_t          hdr_job;
    job_t          head_job;

    logic                 s_read;
    logic [NUM_PE-1:0]    pe_in_write;
    logic [32*NUM_PE-1:0] pe_in_din;
    logic [NUM_PE-1:0]    pe_out_read;
    logic                 m_write;
    logic [31:0]          m_din;
    logic                 pay_xfer;
    logic                 out_xfer;

    always_comb begin
        hdr_job.pe_id   = bus.s_dout[31:28];
        hdr_job.out_len = bus.s_dout[27:16];
        hdr_job.in_len  = bus.s_dout[11:0];
        hdr_job.bad     = int'(bus.s_dout[31:28]) >= NUM_PE;
    end

    // Full is judged on the pre-pop level, so a full queue always stalls the header.
    assign q_full   = (jobq_level == (QW+1)'(JOBQ_DEPTH));
    assign q_empty  = (jobq_level == '0);
    assign head_job = jobq_mem[rd_ptr];

    // ---------------- input side ----------------
    always_comb begin
        in_next     = in_state;
        push        = 1'b0;
        pay_xfer    = 1'b0;
        s_read      = 1'b0;
        pe_in_write = '0;
        pe_in_din   = '0;
        case (in_state)
            IN_HDR: begin
                push   = bus.s_empty_n && !q_full;
                s_read = push;
                if (push && hdr_job.in_len != 12'd0) begin
                    in_next = IN_PAY;
                end
            end
            IN_PAY: begin
                if (in_bad) begin
                    pay_xfer = bus.s_empty_n;
                end else begin
                    for (int k = 0; k < NUM_PE; k++) begin
                        if (in_pe == 4'(k)) begin
                            pay_xfer               = bus.s_empty_n && bus.pe_in_full_n[k];
                            pe_in_write[k]         = pay_xfer;
                            pe_in_din[32*k +: 32]  = bus.s_dout;
                        end
                    end
                end
                s_read = pay_xfer;
                if (pay_xfer && in_cnt == 12'd1) begin
                    in_next = IN_HDR;
                end
            end
            default: in_next = IN_HDR;
        endcase
    end

    always_ff @(posedge ip_clk) begin
        if (srst) begin
            in_state <= IN_HDR;
            in_pe    <= '0;
            in_bad   <= 1'b0;
            in_cnt   <= '0;
        end else begin
            in_state <= in_next;
            if (push) begin
                in_pe  <= hdr_job.pe_id;
                in_bad <= hdr_job.bad;
                in_cnt <= hdr_job.in_len;
            end else if (pay_xfer) begin
                in_cnt <= in_cnt - 12'd1;
            end
        end
    end

    // ---------------- job queue ----------------
    always_ff @(posedge ip_clk) begin
        if (push) begin
            jobq_mem[wr_ptr] <= hdr_job;
        end
    end

    always_ff @(posedge ip_clk) begin
        if (srst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            jobq_level   <= '0;
            bad_id_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + QW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + QW'(1);
            end
            case ({push, pop})
                2'b10:   jobq_level <= jobq_level + 1'b1;
                2'b01:   jobq_level <= jobq_level - 1'b1;
                default: jobq_level <= jobq_level;
            endcase
            if (push && hdr_job.bad && bad_id_count != 8'hFF) begin
                bad_id_count <= bad_id_count + 8'd1;
            end
        end
    end

    // ---------------- output side ----------------
    always_comb begin
        out_next    = out_state;
        pop         = 1'b0;
        out_xfer    = 1'b0;
        m_write     = 1'b0;
        m_din       = '0;
        pe_out_read = '0;
        case (out_state)
            OUT_IDLE: begin
                pop = !q_empty;
                if (pop) begin
                    out_next = OUT_HDR;
                end
            end
            OUT_HDR: begin
                m_din   = {cur_job.pe_id, cur_job.out_len, 3'b000, cur_job.bad, cur_job.in_len};
                m_write = !bus.m_full;
                if (m_write) begin
                    out_next = (cur_job.out_len != 12'd0 && !cur_job.bad) ? OUT_DATA : OUT_IDLE;
                end
            end
            OUT_DATA: begin
                for (int k = 0; k < NUM_PE; k++) begin
                    if (cur_job.pe_id == 4'(k)) begin
                        out_xfer       = bus.pe_out_empty_n[k] && !bus.m_full;
                        pe_out_read[k] = out_xfer;
                        m_din          = bus.pe_out_dout[32*k +: 32];
                    end
                end
                m_write = out_xfer;
                if (out_xfer && out_cnt == 12'd1) begin
                    out_next = OUT_IDLE;
                end
            end
            default: out_next = OUT_IDLE;
        endcase
    end

    always_ff @(posedge ip_clk) begin
        if (srst) begin
            out_state <= OUT_IDLE;
            cur_job   <= '0;
            out_cnt   <= '0;
        end else begin
            out_state <= out_next;
            if (pop) begin
                cur_job <= head_job;
                out_cnt <= head_job.out_len;
            end else if (out_xfer) begin
                out_cnt <= out_cnt - 12'd1;
            end
        end
    end

    assign bus.s_read      = s_read;
    assign bus.pe_in_write = pe_in_write;
    assign bus.pe_in_din   = pe_in_din;
    assign bus.pe_out_read = pe_out_read;
    assign bus.m_write     = m_write;
    assign bus.m_din       = m_din;

    assign in_busy  = (in_state != IN_HDR);
    assign out_busy = (out_state != OUT_IDLE);
endmodule

// File: tb/tb_ap_fifo_job_dispatcher.sv
// Self-checking bench for ap_fifo_job_dispatcher: queue-based job model predicts
// PE writes and the host result stream under randomized back-pressure.
module tb_ap_fifo_job_dispatcher;
    localparam int NUM_PE     = 4;
    localparam int JOBQ_DEPTH = 8;
    localparam int DRAIN_MAX  = 30000;

    logic       ip_clk = 1'b0;
    logic       srst;
    logic [3:0] jobq_level;
    logic       in_busy;
    logic       out_busy;
    logic [7:0] bad_id_count;

    ap_fifo_job_dispatcher_if #(.NUM_PE(NUM_PE)) bus ();

    ap_fifo_job_dispatcher #(.NUM_PE(NUM_PE), .JOBQ_DEPTH(JOBQ_DEPTH)) dut (
        .ip_clk       (ip_clk),
        .srst         (srst),
        .bus          (bus),
        .jobq_level   (jobq_level),
        .in_busy      (in_busy),
        .out_busy     (out_busy),
        .bad_id_count (bad_id_count)
    );

    always #5 ip_clk = ~ip_clk;

    typedef struct {
        int          pe;
        logic [31:0] data;
    } pe_wr_t;

    int          checks = 0;
    int          errors = 0;
    int          viol   = 0;
    int          exp_bad = 0;
    logic [31:0] host_q[$];
    pe_wr_t      exp_wr[$];
    logic [31:0] pe_res[NUM_PE][$];
    logic [31:0] exp_out[$];

    // Job model: host words, expected PE writes, PE results and expected host output.
    task automatic add_job(input int pe, input int out_len, input int in_len, input logic [3:0] junk);
        logic [31:0] hdr;
        logic [31:0] w;
        logic        bad;
        hdr = {4'(pe), 12'(out_len), junk, 12'(in_len)};
        bad = (pe >= NUM_PE);
        host_q.push_back(hdr);
        exp_out.push_back({hdr[31:16], 3'b000, bad, hdr[11:0]});
        if (bad) exp_bad = (exp_bad < 255) ? exp_bad + 1 : 255;
        for (int i = 0; i < in_len; i++) begin
            w = $urandom;
            host_q.push_back(w);
            if (!bad) exp_wr.push_back('{pe, w});
        end
        if (!bad) begin
            for (int i = 0; i < out_len; i++) begin
                w = $urandom;
                pe_res[pe].push_back(w);
                exp_out.push_back(w);
            end
        end
    endtask

    task automatic idle_inputs();
        bus.s_empty_n      = 1'b0;
        bus.s_dout         = '0;
        bus.pe_in_full_n   = '1;
        bus.pe_out_dout    = '0;
        bus.pe_out_empty_n = '0;
        bus.m_full         = 1'b0;
    endtask

    task automatic clear_model();
        host_q.delete();
        exp_wr.delete();
        exp_out.delete();
        for (int k = 0; k < NUM_PE; k++) pe_res[k].delete();
        exp_bad = 0;
    endtask

    // One clock: drive at negedge, observe strobes 1ns later, transfers land at posedge.
    task automatic cycle(input bit rand_bp, input bit force_mfull);
        logic [32*NUM_PE-1:0] exp_vec;
        logic [NUM_PE-1:0]    exp_sel;
        logic [31:0]          exp_word;
        pe_wr_t               e;
        @(negedge ip_clk);
        bus.s_empty_n = (host_q.size() != 0) && (!rand_bp || $urandom_range(0, 3) != 0);
        bus.s_dout    = (host_q.size() != 0) ? host_q[0] : $urandom;
        for (int k = 0; k < NUM_PE; k++) begin
            bus.pe_in_full_n[k] = !rand_bp || $urandom_range(0, 2) != 0;
            if (pe_res[k].size() != 0) begin
                bus.pe_out_empty_n[k]        = !rand_bp || $urandom_range(0, 2) != 0;
                bus.pe_out_dout[32*k +: 32]  = pe_res[k][0];
            end else begin
                bus.pe_out_empty_n[k]        = 1'b0;
                bus.pe_out_dout[32*k +: 32]  = $urandom;
            end
        end
        bus.m_full = force_mfull || (rand_bp && $urandom_range(0, 2) == 0);
        #1;
        if (bus.s_read) begin
            if (!bus.s_empty_n) viol++;
            else void'(host_q.pop_front());
        end
        if (bus.pe_in_write != '0) begin
            if ($countones(bus.pe_in_write) != 1 || !bus.s_read) viol++;
            if ((bus.pe_in_write & ~bus.pe_in_full_n) != '0) viol++;
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL pe_write unexpected: pe_in_write=%b, required no write", bus.pe_in_write);
            end else begin
                e = exp_wr.pop_front();
                exp_vec = '0;
                exp_vec[32*e.pe +: 32] = e.data;
                exp_sel = '0;
                exp_sel[e.pe] = 1'b1;
                if (bus.pe_in_write !== exp_sel || bus.pe_in_din !== exp_vec) begin
                    errors++;
                    $display("FAIL pe_write: sel=%b din=%h, required sel=%b din=%h",
                             bus.pe_in_write, bus.pe_in_din, exp_sel, exp_vec);
                end
            end
        end
        if (bus.pe_out_read != '0) begin
            if ($countones(bus.pe_out_read) != 1 || !bus.m_write) viol++;
            if ((bus.pe_out_read & ~bus.pe_out_empty_n) != '0) viol++;
            for (int k = 0; k < NUM_PE; k++)
                if (bus.pe_out_read[k] && pe_res[k].size() != 0) void'(pe_res[k].pop_front());
        end
        if (bus.m_write) begin
            if (bus.m_full) viol++;
            checks++;
            if (exp_out.size() == 0) begin
                errors++;
                $display("FAIL m_write unexpected: m_din=%h, required no write", bus.m_din);
            end else begin
                exp_word = exp_out.pop_front();
                if (bus.m_din !== exp_word) begin
                    errors++;
                    $display("FAIL m_din: got %h, required %h", bus.m_din, exp_word);
                end
            end
        end
    endtask

    task automatic run_traffic(input string name, input int max_cycles, input bit drain,
                               input bit rand_bp, input bit force_mfull);
        int n;
        bit done;
        viol = 0;
        n    = 0;
        done = 1'b0;
        while (n < max_cycles && !(drain && done)) begin
            cycle(rand_bp, force_mfull);
            n++;
            done = host_q.size() == 0 && exp_out.size() == 0 && exp_wr.size() == 0;
        end
        if (drain) begin
            checks++;
            if (!done) begin
                errors++;
                $display("FAIL %s drain timeout: host=%0d pe=%0d out=%0d words left, required 0",
                         name, host_q.size(), exp_wr.size(), exp_out.size());
            end
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL %s strobe rules: %0d violations, required 0", name, viol);
        end
    endtask

    task automatic settle();
        @(negedge ip_clk);
        idle_inputs();
        repeat (2) @(negedge ip_clk);
        #1;
    endtask

    task automatic test_reset();
        srst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge ip_clk);
        #1;
        checks++;
        if ({bus.s_read, bus.pe_in_write, bus.pe_out_read, bus.m_write} !== '0) begin
            errors++;
            $display("FAIL reset strobes: s_read=%b pe_in_write=%b pe_out_read=%b m_write=%b, required 0",
                     bus.s_read, bus.pe_in_write, bus.pe_out_read, bus.m_write);
        end
        checks++;
        if (bus.m_din !== '0 || bus.pe_in_din !== '0) begin
            errors++;
            $display("FAIL reset data: m_din=%h pe_in_din=%h, required 0", bus.m_din, bus.pe_in_din);
        end
        checks++;
        if (jobq_level !== '0 || in_busy !== 1'b0 || out_busy !== 1'b0 || bad_id_count !== '0) begin
            errors++;
            $display("FAIL reset status: level=%0d in_busy=%b out_busy=%b bad=%0d, required 0",
                     jobq_level, in_busy, out_busy, bad_id_count);
        end
        @(negedge ip_clk);
        srst = 1'b0;
    endtask

    task automatic test_basic();
        add_job(1, 3, 4, 4'h0);
        run_traffic("basic", DRAIN_MAX, 1'b1, 1'b0, 1'b0);
        settle();
        checks++;
        if (jobq_level !== '0 || {in_busy, out_busy} !== 2'b00) begin
            errors++;
            $display("FAIL basic end: level=%0d busy=%b%b, required 0 00", jobq_level, in_busy, out_busy);
        end
    endtask

    task automatic test_order();
        add_job(2, 3, 2, 4'h5);
        add_job(0, 4, 3, 4'hA);
        run_traffic("order", DRAIN_MAX, 1'b1, 1'b0, 1'b0);
        settle();
        checks++;
        if (jobq_level !== '0 || pe_res[0].size() != 0 || pe_res[2].size() != 0) begin
            errors++;
            $display("FAIL order end: level=%0d pe0_left=%0d pe2_left=%0d, required 0",
                     jobq_level, pe_res[0].size(), pe_res[2].size());
        end
    endtask

    task automatic test_bad_id();
        add_job(7, 2, 2, 4'h0);
        run_traffic("bad_id", DRAIN_MAX, 1'b1, 1'b0, 1'b0);
        settle();
        checks++;
        if (bad_id_count !== 8'(exp_bad) || jobq_level !== '0) begin
            errors++;
            $display("FAIL bad_id count: got %0d level=%0d, required %0d level=0",
                     bad_id_count, jobq_level, exp_bad);
        end
    endtask

    task automatic test_queue_full();
        for (int i = 0; i < JOBQ_DEPTH + 2; i++) add_job($urandom_range(0, NUM_PE - 1), 0, 0, 4'h0);
        run_traffic("queue_full stall", 40, 1'b0, 1'b0, 1'b1);
        checks++;
        if (host_q.size() != 1 || jobq_level !== 4'(JOBQ_DEPTH) || bus.s_read !== 1'b0 || in_busy !== 1'b0) begin
            errors++;
            $display("FAIL queue_full stall: unread=%0d level=%0d s_read=%b in_busy=%b, required 1 %0d 0 0",
                     host_q.size(), jobq_level, bus.s_read, in_busy, JOBQ_DEPTH);
        end
        cycle(1'b0, 1'b0);
        checks++;
        if (host_q.size() != 1) begin
            errors++;
            $display("FAIL queue_full echo cycle: unread=%0d, required 1", host_q.size());
        end
        cycle(1'b0, 1'b0);
        checks++;
        if (host_q.size() != 1) begin
            errors++;
            $display("FAIL queue_full pop cycle: unread=%0d, required 1", host_q.size());
        end
        cycle(1'b0, 1'b0);
        checks++;
        if (host_q.size() != 0) begin
            errors++;
            $display("FAIL queue_full after pop: unread=%0d, required 0", host_q.size());
        end
        run_traffic("queue_full drain", DRAIN_MAX, 1'b1, 1'b0, 1'b0);
        settle();
        checks++;
        if (jobq_level !== '0 || out_busy !== 1'b0) begin
            errors++;
            $display("FAIL queue_full end: level=%0d out_busy=%b, required 0 0", jobq_level, out_busy);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 3; i++)
            add_job($urandom_range(0, NUM_PE - 1), $urandom_range(50, 100), 100, 4'($urandom_range(0, 15)));
        run_traffic("backpressure", DRAIN_MAX, 1'b1, 1'b1, 1'b0);
        settle();
        checks++;
        if (jobq_level !== '0 || {in_busy, out_busy} !== 2'b00) begin
            errors++;
            $display("FAIL backpressure end: level=%0d busy=%b%b, required 0 00", jobq_level, in_busy, out_busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++)
            add_job($urandom_range(0, 7), $urandom_range(0, 20), $urandom_range(0, 20), 4'($urandom_range(0, 15)));
        run_traffic("random", DRAIN_MAX, 1'b1, 1'b1, 1'b0);
        settle();
        checks++;
        if (jobq_level !== '0 || bad_id_count !== 8'(exp_bad)) begin
            errors++;
            $display("FAIL random end: level=%0d bad=%0d, required 0 %0d", jobq_level, bad_id_count, exp_bad);
        end
    endtask

    task automatic test_max_len();
        add_job(3, 4095, 4095, 4'hF);
        run_traffic("max_len", DRAIN_MAX, 1'b1, 1'b0, 1'b0);
        settle();
        checks++;
        if (jobq_level !== '0 || {in_busy, out_busy} !== 2'b00) begin
            errors++;
            $display("FAIL max_len end: level=%0d busy=%b%b, required 0 00", jobq_level, in_busy, out_busy);
        end
    endtask

    task automatic test_bad_saturate();
        for (int i = 0; i < 260; i++) add_job(NUM_PE + (i % (16 - NUM_PE)), 0, 0, 4'h0);
        run_traffic("bad_saturate", DRAIN_MAX, 1'b1, 1'b0, 1'b0);
        settle();
        checks++;
        if (bad_id_count !== 8'd255 || exp_bad != 255) begin
            errors++;
            $display("FAIL bad_saturate: got %0d, required 255", bad_id_count);
        end
    endtask

    task automatic test_srst_mid();
        add_job(1, 0, 100, 4'h0);
        run_traffic("srst_mid pre", 20, 1'b0, 1'b0, 1'b0);
        @(negedge ip_clk);
        idle_inputs();
        srst = 1'b1;
        @(negedge ip_clk);
        srst = 1'b0;
        #1;
        checks++;
        if ({bus.s_read, bus.pe_in_write, bus.pe_out_read, bus.m_write} !== '0 ||
            bus.m_din !== '0 || bus.pe_in_din !== '0) begin
            errors++;
            $display("FAIL srst_mid outputs: s_read=%b pe_in_write=%b pe_out_read=%b m_write=%b m_din=%h, required 0",
                     bus.s_read, bus.pe_in_write, bus.pe_out_read, bus.m_write, bus.m_din);
        end
        checks++;
        if (jobq_level !== '0 || in_busy !== 1'b0 || out_busy !== 1'b0 || bad_id_count !== '0) begin
            errors++;
            $display("FAIL srst_mid status: level=%0d in_busy=%b out_busy=%b bad=%0d, required 0",
                     jobq_level, in_busy, out_busy, bad_id_count);
        end
        clear_model();
        add_job(0, 0, 1, 4'h0);
        run_traffic("srst_mid fresh", DRAIN_MAX, 1'b1, 1'b0, 1'b0);
        settle();
        checks++;
        if (jobq_level !== '0 || {in_busy, out_busy} !== 2'b00) begin
            errors++;
            $display("FAIL srst_mid fresh end: level=%0d busy=%b%b, required 0 00", jobq_level, in_busy, out_busy);
        end
    endtask

    initial begin
        idle_inputs();
        srst = 1'b1;
        test_reset();
        test_basic();
        test_order();
        test_bad_id();
        test_queue_full();
        test_backpressure();
        test_random();
        test_max_len();
        test_bad_saturate();
        test_srst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
